adder_result_fifo: RTL
======================

// Module: adder_result_fifo
// PURPOSE
//   Result buffer directly downstream of adder64. Captures {cout,sum} on every cycle the adder asserts rdy.
//   Holds results in a DEPTH-entry show-ahead FIFO and hands them to the consumer over a valid/ready handshake.
//   adder64 has no backpressure, so a result arriving while the FIFO is full and not popping is dropped and counted.
// PARAMETERS
//   LEN_DATA   64   width of sum; matches `LEN_DATA used by adder64
//   DEPTH      8    FIFO entries; power of two, >= 2
//   CNT_W      16   width of drop counter
// PORTS
//   clk        in   1                  single clock, all state on posedge
//   rst        in   1                  synchronous, active-high reset
//   en         in   1                  capture enable; 0 = ignore in_rdy (pops still allowed)
//   in_rdy     in   1                  adder64 rdy: in_sum/in_cout valid this cycle
//   in_sum     in   LEN_DATA           adder64 sum
//   in_cout    in   1                  adder64 cout
//   out_valid  out  1                  head entry available
//   out_ready  in   1                  consumer accepts head this cycle
//   out_sum    out  LEN_DATA           head sum; 0 when empty
//   out_cout   out  1                  head cout; 0 when empty
//   level      out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//   full       out  1                  level == DEPTH
//   empty      out  1                  level == 0
//   drop_cnt   out  CNT_W              results lost to overflow, saturating
//   overflow   out  1                  sticky: set on first drop, cleared only by rst
// BEHAVIOUR
//   - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, level=0, out_valid=0, out_sum=0, out_cout=0, full=0, empty=1,
//     drop_cnt=0, overflow=0. Storage array is not reset. rst wins over any simultaneous push/pop; in-flight data discarded.
//   - push_req = en & in_rdy.  pop = out_valid & out_ready.
//   - push = push_req & (~full | pop). A full FIFO popping this cycle accepts the new result (level stays DEPTH).
//   - drop = push_req & full & ~pop -> drop_cnt += 1 (holds at 2^CNT_W-1), overflow <= 1. FIFO contents unchanged.
//   - push: mem[wr_ptr] <= {in_cout,in_sum}; wr_ptr <= wr_ptr+1 (mod DEPTH, natural wrap).
//   - pop: rd_ptr <= rd_ptr+1 (mod DEPTH). out_ready while out_valid=0 has no effect.
//   - level: +1 on push only, -1 on pop only, unchanged on both or neither.
//   - Show-ahead: out_valid = ~empty; out_sum/out_cout = mem[rd_ptr] combinationally, forced to 0 when empty.
//   - Latency: result captured at posedge N is visible at out_* after posedge N (one cycle, no bypass when empty).
//   - Empty + push + out_ready same cycle: no pop (out_valid=0); entry appears next cycle.
//   - Order preserved strictly FIFO; no reordering, no duplication.
//   - out_* stable while out_valid=1 and out_ready=0.
//   - full/empty/level are derived from the registered count, never from in-cycle requests.
// TESTING
//   1 Reset: rst=1 two cycles with in_rdy=1 -> level=0, empty=1, out_valid=0, out_sum=0, drop_cnt=0.
//   2 Single: en=1, in_rdy pulse with sum=64'h0000_0000_DEAD_BEEF, cout=1, out_ready=0 -> next cycle out_valid=1,
//     out_sum=DEAD_BEEF, out_cout=1, level=1; hold out_ready=0 3 cycles -> outputs unchanged.
//   3 Fill/overflow: DEPTH=8, push 10 results sum=1..10, out_ready=0 -> full=1, level=8, drop_cnt=2, overflow=1;
//     then out_ready=1 -> out_sum sequence 1..8, then empty=1, out_sum=0.
//   4 Full + simultaneous push/pop: FIFO full with 1..8, push 9 with out_ready=1 -> no drop, level=8,
//     drained order 2..9.
//   5 Wrap-around: stream 20 results (sum=k) with out_ready=1 every cycle -> level<=1 throughout, outputs 1..20 in order,
//     drop_cnt=0.
//   6 en gating + mid-op reset: en=0 with in_rdy=1 -> level unchanged; with 5 entries, assert rst -> next cycle empty=1,
//     drop_cnt=0, overflow=0; push after release -> FIFO operates normally.

Source files
------------

// File: rtl/adder_result_fifo.sv
// Result buffer behind adder64: captures {cout,sum} on rdy into a show-ahead FIFO
// drained by a valid/ready consumer; results arriving while full and not popping are dropped and counted.
module adder_result_fifo #(
  parameter int LEN_DATA = 64,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_rdy,
  input  logic [LEN_DATA-1:0]        in_sum,
  input  logic                       in_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LEN_DATA-1:0]        out_sum,
  output logic                       out_cout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [LEN_DATA:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push_req;
  logic              pop;
  logic              push;
  logic              drop;
  logic [LEN_DATA:0] head;

  always_comb begin
    push_req = en & in_rdy;
    pop      = out_valid & out_ready;
    // A full FIFO that pops this cycle frees a slot for the incoming result.
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  always_comb begin
    full      = (count == FULL_LVL);
    empty     = (count == '0);
    level     = count;
    out_valid = ~empty;
    head      = mem[rd_ptr];
    out_sum   = empty ? '0 : head[LEN_DATA-1:0];
    out_cout  = empty ? 1'b0 : head[LEN_DATA];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {in_cout, in_sum};
  end

endmodule
